// File: rtl/am_src_arb_if.sv
// Handshake bundle for the two-source arbiter: requester A, requester B,
// the arbitration controls and the downstream output port.
interface am_src_arb_if #(
    parameter int CNT_W = 4
);
    logic [15:0]      i_aData;
    logic             i_aValid;
    logic             o_aReady;
    logic [15:0]      i_bData;
    logic             i_bValid;
    logic             o_bReady;
    logic [1:0]       i_mode;
    logic [CNT_W-1:0] i_burst;
    logic             o_s;
    logic [15:0]      o_data;
    logic             o_valid;
    logic             i_oReady;

    // The arbiter itself
    modport slave (
        input  i_aData, i_aValid, i_bData, i_bValid, i_mode, i_burst, i_oReady,
        output o_aReady, o_bReady, o_s, o_data, o_valid
    );

    // Whoever drives the requesters and consumes the output
    modport master (
        output i_aData, i_aValid, i_bData, i_bValid, i_mode, i_burst, i_oReady,
        input  o_aReady, o_bReady, o_s, o_data, o_valid
    );
endinterface

// File: rtl/am_src_arb.sv
// Two-source arbiter feeding a registered 16-bit mux bank. One side is granted
// at a time; S selects A (DI side) or B (CI side) and only moves on the edge
// where the grant changes, so a transfer never mixes data from the wrong side.
module am_src_arb #(
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    am_src_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_data;
    logic             r_valid;

    logic             w_adv;
    logic             w_aXfer;
    logic             w_bXfer;
    logic             w_xfer;
    logic [CNT_W:0]   w_cntInc;
    logic [CNT_W:0]   w_burstEff;
    logic             w_burstDone;
    logic             w_aV;
    logic             w_bV;

    assign w_aV = bus.i_aValid;
    assign w_bV = bus.i_bValid;

    // Output register can take a new sample when empty or being drained now
    assign w_adv = ~r_valid | bus.i_oReady;

    assign bus.o_aReady = (r_state == GNT_A) & w_adv;
    assign bus.o_bReady = (r_state == GNT_B) & w_adv;

    assign w_aXfer = w_aV & bus.o_aReady;
    assign w_bXfer = w_bV & bus.o_bReady;
    assign w_xfer  = w_aXfer | w_bXfer;

    // Burst limit: a programmed 0 behaves as 1; the compare is one bit wider
    // so a saturated counter plus one still compares correctly
    assign w_cntInc    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_burstEff  = (bus.i_burst == '0) ? {{CNT_W{1'b0}}, 1'b1}
                                             : {1'b0, bus.i_burst};
    assign w_burstDone = w_xfer & (w_cntInc >= w_burstEff);

    assign bus.o_s     = r_sel;
    assign bus.o_data  = r_data;
    assign bus.o_valid = r_valid;

    // Grant decision for the next cycle from current valids, mode and burst count
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_aV && !w_bV) begin
                    w_nextState = GNT_A;
                end else if (!w_aV && w_bV) begin
                    w_nextState = GNT_B;
                end else if (w_aV && w_bV) begin
                    case (bus.i_mode)
                        2'b00:   w_nextState = r_sel ? GNT_A : GNT_B;
                        2'b01:   w_nextState = GNT_A;
                        2'b10:   w_nextState = GNT_B;
                        default: w_nextState = r_sel ? GNT_B : GNT_A;
                    endcase
                end
            end
            GNT_A: begin
                case (bus.i_mode)
                    2'b00: begin
                        if (w_bV && (!w_aV || w_burstDone)) w_nextState = GNT_B;
                        else if (!w_aV && !w_bV)            w_nextState = IDLE;
                    end
                    2'b01: begin
                        if (!w_aV) w_nextState = w_bV ? GNT_B : IDLE;
                    end
                    2'b10: begin
                        if (w_bV)       w_nextState = GNT_B;
                        else if (!w_aV) w_nextState = IDLE;
                    end
                    default: begin
                        if (!w_aV) w_nextState = IDLE;
                    end
                endcase
            end
            GNT_B: begin
                case (bus.i_mode)
                    2'b00: begin
                        if (w_aV && (!w_bV || w_burstDone)) w_nextState = GNT_A;
                        else if (!w_aV && !w_bV)            w_nextState = IDLE;
                    end
                    2'b10: begin
                        if (!w_bV) w_nextState = w_aV ? GNT_A : IDLE;
                    end
                    2'b01: begin
                        if (w_aV)       w_nextState = GNT_A;
                        else if (!w_bV) w_nextState = IDLE;
                    end
                    default: begin
                        if (!w_bV) w_nextState = IDLE;
                    end
                endcase
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, select, burst counter and output sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
            r_data  <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) begin
                r_cnt <= '0;
                if (w_nextState == GNT_A)      r_sel <= 1'b0;
                else if (w_nextState == GNT_B) r_sel <= 1'b1;
            end else if (w_xfer && (r_cnt != CNT_MAX)) begin
                r_cnt <= w_cntInc[CNT_W-1:0];
            end
            if (w_xfer) begin
                r_data  <= r_sel ? bus.i_bData : bus.i_aData;
                r_valid <= 1'b1;
            end else if (bus.i_oReady) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_am_src_arb.sv
// Bench for am_src_arb: directed scenarios, a grant-owner model checked every
// cycle, and literal expectations on the observed sample order.
module tb_am_src_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cyc = '0;
    bit          autoData = 1'b1;
    int          nCompared = 0;
    int          nFailed = 0;
    logic [15:0] seen[$];

    // Model state: owner 0 none / 1 A / 2 B, side last granted, beats in grant
    int          mOwner = 0;
    int          mSide = 0;
    int          mBeats = 0;
    bit          mValid = 1'b0;
    logic [15:0] mData = '0;

    am_src_arb_if #(.CNT_W(4)) bus ();

    am_src_arb #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Who should own the grant next, stated from the arbitration rules
    function automatic int nextOwner(input int cur, input bit a, input bit b, input int m,
                                     input int limit, input int beatsAfter, input bit moved,
                                     input int side);
        bit own;
        bit other;
        if (cur == 0) begin
            if (a && b) begin
                if (m == 0) return (side == 0) ? 2 : 1;
                if (m == 1) return 1;
                if (m == 2) return 2;
                return (side == 0) ? 1 : 2;
            end
            if (a) return 1;
            if (b) return 2;
            return 0;
        end
        own   = (cur == 1) ? a : b;
        other = (cur == 1) ? b : a;
        if (m == 0) begin
            if (other && (!own || (moved && beatsAfter >= limit))) return 3 - cur;
            return (own || other) ? cur : 0;
        end
        if (m == 3) return own ? cur : 0;
        if ((m == 1) ? a : b) return m;
        if ((m == 1) ? b : a) return 3 - m;
        return 0;
    endfunction

    // Behavioural model advanced on every clock edge, cleared by reset
    always @(posedge clk or negedge rst_n) begin : model
        int  limit;
        int  nxt;
        bit  room;
        bit  aGo;
        bit  bGo;
        if (!rst_n) begin
            mOwner <= 0;
            mSide  <= 0;
            mBeats <= 0;
            mValid <= 1'b0;
            mData  <= '0;
        end else begin
            limit = (bus.i_burst == 0) ? 1 : int'(bus.i_burst);
            room  = !mValid || bus.i_oReady;
            aGo   = (mOwner == 1) && room && bus.i_aValid;
            bGo   = (mOwner == 2) && room && bus.i_bValid;
            nxt   = nextOwner(mOwner, bus.i_aValid, bus.i_bValid, int'(bus.i_mode),
                              limit, mBeats + 1, aGo || bGo, mSide);
            if (aGo || bGo) begin
                mData  <= aGo ? bus.i_aData : bus.i_bData;
                mValid <= 1'b1;
            end else if (bus.i_oReady) begin
                mValid <= 1'b0;
            end
            if (nxt != mOwner) begin
                mBeats <= 0;
                if (nxt != 0) mSide <= nxt - 1;
            end else if ((aGo || bGo) && mBeats < 15) begin
                mBeats <= mBeats + 1;
            end
            mOwner <= nxt;
        end
    end

    // Compare every output against the model on each falling edge
    task automatic checkOutput();
        bit room;
        room = !mValid || bus.i_oReady;
        checkEq("aReady", bus.o_aReady, (mOwner == 1) && room);
        checkEq("bReady", bus.o_bReady, (mOwner == 2) && room);
        checkEq("oValid", bus.o_valid, mValid);
        checkEq("sel", bus.o_s, mSide[0]);
        if (mValid) checkEq("oData", bus.o_data, mData);
    endtask

    always @(negedge clk) begin
        checkOutput();
        if (rst_n && bus.o_valid && bus.i_oReady) seen.push_back(bus.o_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (autoData) begin
            bus.i_aData = {4'hA, cyc};
            bus.i_bData = {4'hB, cyc};
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic bV, input logic oR,
                                 input logic [1:0] m, input logic [3:0] bu);
        bus.i_aValid = aV;
        bus.i_bValid = bV;
        bus.i_oReady = oR;
        bus.i_mode   = m;
        bus.i_burst  = bu;
    endtask

    // Hold reset two cycles with the given stimulus, release, clear the log
    task automatic applyReset(input logic aV, input logic bV, input logic oR,
                              input logic [1:0] m, input logic [3:0] bu);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'd1);
        tick();
        applyStimulus(aV, bV, oR, m, bu);
        tick();
        rst_n = 1'b1;
        seen.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bit got;
        int bCount;
        bus.i_aData = '0;
        bus.i_bData = '0;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 4'd2);

        // Reset values and readies held low through and just after release
        tick();
        tick();
        checkEq("rstValid", bus.o_valid, 1'b0);
        checkEq("rstData", bus.o_data, 16'h0000);
        checkEq("rstSel", bus.o_s, 1'b0);
        checkEq("rstReady", {bus.o_aReady, bus.o_bReady}, 2'b00);

        // Round robin, burst 2: A goes first alone, then both compete
        applyReset(1'b1, 1'b0, 1'b1, 2'b00, 4'd2);
        #2;
        checkEq("postRelReady", {bus.o_aReady, bus.o_bReady}, 2'b00);
        tick();
        bus.i_bValid = 1'b1;
        repeat (9) tick();
        checkEq("rrCount", seen.size() >= 6, 1'b1);
        if (seen.size() >= 6) begin
            checkEq("rr0", seen[0][15:12], 4'hA);
            checkEq("rr1", seen[1][15:12], 4'hA);
            checkEq("rr2", seen[2][15:12], 4'hB);
            checkEq("rr3", seen[3][15:12], 4'hB);
            checkEq("rr4", seen[4][15:12], 4'hA);
            checkEq("rr5", seen[5][15:12], 4'hA);
        end

        // Burst 0 acts as 1: strict alternation
        bus.i_burst = 4'd0;
        tick();
        tick();
        seen.delete();
        repeat (6) tick();
        checkEq("altCount", seen.size() >= 5, 1'b1);
        for (int k = 0; k + 1 < seen.size() && k < 4; k++)
            checkEq("alt", seen[k+1][15:12], (seen[k][15:12] == 4'hA) ? 4'hB : 4'hA);

        // Downstream stall for 5 cycles: nothing accepted, output held
        bus.i_oReady = 1'b0;
        repeat (5) begin
            tick();
            checkEq("stallValid", bus.o_valid, 1'b1);
            checkEq("stallReady", {bus.o_aReady, bus.o_bReady}, 2'b00);
        end
        bus.i_oReady = 1'b1;
        tick();

        // A priority: B starves while A is valid, then gets the grant quickly
        applyReset(1'b1, 1'b1, 1'b1, 2'b01, 4'd2);
        repeat (6) tick();
        checkEq("prioCount", seen.size() >= 4, 1'b1);
        foreach (seen[k]) checkEq("prioOnlyA", seen[k][15:12], 4'hA);
        bus.i_aValid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            tick();
            got = bus.o_s;
        end
        checkEq("bGrantWithin2", got, 1'b1);

        // Reset while holding a B sample of 1234 must discard it
        autoData = 1'b0;
        bus.i_bData = 16'h1234;
        bus.i_aData = 16'h0000;
        applyReset(1'b0, 1'b1, 1'b0, 2'b00, 4'd2);
        repeat (4) tick();
        checkEq("heldData", bus.o_data, 16'h1234);
        checkEq("heldValid", bus.o_valid, 1'b1);
        checkEq("heldSel", bus.o_s, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("asyncValid", bus.o_valid, 1'b0);
        checkEq("asyncData", bus.o_data, 16'h0000);
        checkEq("asyncSel", bus.o_s, 1'b0);
        bus.i_bValid = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.i_aData  = 16'h5678;
        bus.i_aValid = 1'b1;
        bus.i_oReady = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            got = bus.o_valid;
        end
        checkEq("postRstValid", got, 1'b1);
        checkEq("postRstData", bus.o_data, 16'h5678);
        autoData = 1'b1;

        // Lock mode in GNT_B: three B beats, then idle, then A
        applyReset(1'b0, 1'b1, 1'b1, 2'b11, 4'd2);
        tick();
        bus.i_aValid = 1'b1;
        bCount = 0;
        for (int k = 0; k < 20 && bCount < 3; k++) begin
            @(negedge clk);
            if (bus.o_bReady && bus.i_bValid) bCount++;
        end
        checkEq("lockBeats", bCount, 3);
        tick();
        bus.i_bValid = 1'b0;
        repeat (6) tick();
        checkEq("lockCount", seen.size() >= 4, 1'b1);
        if (seen.size() >= 4) begin
            checkEq("lock0", seen[0][15:12], 4'hB);
            checkEq("lock1", seen[1][15:12], 4'hB);
            checkEq("lock2", seen[2][15:12], 4'hB);
            checkEq("lock3", seen[3][15:12], 4'hA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/am_src_arb.md
AM_SRC_ARB -- requirements
Module: am_src_arb

Interface
REQ-001 SHALL have parameter: CNT_W, 4, burst counter and BURST input width (range 2..8).
REQ-002 SHALL have port: CLK  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: A_DATA  in  16  requester A sample, routed to mux-bank DI side.
REQ-005 SHALL have port: A_VALID / A_READY  in / out  1 / 1  requester A handshake.
REQ-006 SHALL have port: B_DATA  in  16  requester B sample, routed to mux-bank CI side.
REQ-007 SHALL have port: B_VALID / B_READY  in / out  1 / 1  requester B handshake.
REQ-008 SHALL have port: MODE  in  2  00 round-robin, 01 A-priority, 10 B-priority, 11 lock to current grant.
REQ-009 SHALL have port: BURST  in  CNT_W  maximum consecutive round-robin transfers per grant; 0 is treated as 1.
REQ-010 SHALL have port: S  out  1  registered select to the 16-bit mux bank (0 = A/DI, 1 = B/CI).
REQ-011 SHALL have port: O_DATA  out  16  registered output sample.
REQ-012 SHALL have port: O_VALID / O_READY  out / in  1 / 1  downstream handshake.

Function
REQ-013 SHALL implement states IDLE, GNT_A and GNT_B; S = 0 in GNT_A, S = 1 in GNT_B, and S holds its last value in IDLE.
REQ-014 SHALL define adv = ~O_VALID | O_READY (output register free, or being drained this cycle).
REQ-015 SHALL drive A_READY = (state == GNT_A) & adv and B_READY = (state == GNT_B) & adv, combinationally; both SHALL be 0 in IDLE.
REQ-016 SHALL treat a transfer as X_VALID & X_READY; on a transfer O_DATA <= the muxed sample (A_DATA when S = 0, B_DATA when S = 1) and O_VALID <= 1, one-cycle latency.
REQ-017 SHALL clear O_VALID when O_READY = 1 and no transfer occurs that cycle; O_DATA SHALL hold while O_VALID = 1 and O_READY = 0.
REQ-018 SHALL, from IDLE, go to GNT_A if only A_VALID, to GNT_B if only B_VALID, and resolve A_VALID & B_VALID per MODE: 00 → opposite of S, 01 → A, 10 → B, 11 → the side selected by S.
REQ-019 SHALL count transfers in the current grant with an up-counter cnt, cleared to 0 on every state change and saturating at 2^CNT_W-1.
REQ-020 SHALL switch grant GNT_X→GNT_Y (MODE 00) when Y_VALID and either X_VALID = 0 or a transfer brings cnt+1 ≥ max(BURST,1).
REQ-021 SHALL switch grant immediately to the priority side when that side is valid (MODE 01/10); the non-priority side SHALL be granted only while the priority side is not valid.
REQ-022 SHALL never switch grant in MODE 11; it SHALL return to IDLE only when the granted side is not valid.
REQ-023 SHALL go from GNT_X to IDLE when neither side is valid and no switch condition applies.
REQ-024 SHALL make S change only at the clock edge of a state change, so no cycle contains a transfer whose data came from the non-selected side.
REQ-025 SHALL sample MODE and BURST each cycle; a change SHALL affect only the next transition decision.
REQ-026 SHALL never assert A_READY and B_READY in the same cycle.

Reset
REQ-027 SHALL, while RST_N = 0, force state = IDLE, S = 0, cnt = 0, O_VALID = 0 and O_DATA = 16'h0000, asynchronously.
REQ-028 SHALL discard any buffered sample on reset assertion mid-transfer; the first post-reset O_VALID SHALL come from a new transfer.
REQ-029 SHALL leave A_READY and B_READY at 0 during reset and in the first cycle after release.

Verification
REQ-030 SHALL cover: MODE = 00, BURST = 2, A and B always valid, O_READY = 1 → O_DATA order A,A,B,B,A,A; S toggles every 2 transfers.
REQ-031 SHALL cover: MODE = 01, A valid continuously, B valid → only A data on O_DATA; B granted within 2 cycles of A_VALID dropping.
REQ-032 SHALL cover: O_READY = 0 for 5 cycles with O_VALID = 1 → O_DATA stable, A_READY = B_READY = 0, S unchanged.
REQ-033 SHALL cover: BURST = 0, MODE = 00, both valid → strict alternation A,B,A,B.
REQ-034 SHALL cover: RST_N pulled low while O_VALID = 1 and O_DATA = 16'h1234 → O_VALID = 0, O_DATA = 0, S = 0 same cycle; no stale 16'h1234 after release.
REQ-035 SHALL cover: MODE = 11 in GNT_B, A valid, B valid for 3 beats then idle → 3 B transfers, then IDLE, then GNT_A.
